// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
//   Shared definitions for the data-memory responder:
//   - RV32I load/store funct3 encodings
//   - responder FSM state encoding
// -----------------------------------------------------------------------------
package mem_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      RESP = 2'd2
   } state_e;

endpackage

// File: rtl/data_mem_resp_sp_ram.sv
// -----------------------------------------------------------------------------
// sp_ram
//   Single-port synchronous RAM, 2^ADDR_W words of 32 bits, registered read,
//   no reset (contents and read register power up undefined).
//   Ports:
//     clk     in   clock, rising edge
//     en      in   access enable
//     we      in   1 = write wdata to addr, 0 = read addr into rdata
//     addr    in   word address
//     wdata   in   write data
//     rdata   out  read data, valid the cycle after a read access
// -----------------------------------------------------------------------------
module sp_ram #(
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              en,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata
);

   logic [31:0] mem_q [2**ADDR_W];
   logic [31:0] rdata_q;

   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            mem_q[addr] <= wdata;
         end else begin
            rdata_q <= mem_q[addr];
         end
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_resp.sv
// -----------------------------------------------------------------------------
// data_mem_resp
//   Responder end of the CPU data-memory port. Accepts one load/store at a
//   time, performs RV32I byte/half/word accesses on an internal sp_ram and
//   returns extended load data as a single-cycle response pulse.
//
//   Handshake: a request is accepted on a rising edge where req_valid and
//   req_ready are both high; req_ready is high only in IDLE. Every accepted
//   request produces exactly one rsp_valid pulse; there is no response
//   backpressure. rsp_rdata/rsp_err are meaningful only while rsp_valid = 1.
//
//   Ports:
//     clk, reset (async, active-low)
//     req_valid/req_ready, req_we, req_funct3, req_addr (byte), req_wdata
//     rsp_valid, rsp_rdata, rsp_err
//     dbg_state   current FSM state
// -----------------------------------------------------------------------------
module data_mem_resp
   import mem_pkg::*;
#(
   parameter int ADDR_W = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output state_e      dbg_state
);

   state_e            state_q;
   logic              we_q;
   logic [2:0]        f3_q;
   logic [1:0]        lane_q;
   logic [ADDR_W-1:0] idx_q;
   logic [15:0]       wdata_q;   // only sb/sh use latched data
   logic              rsp_valid_q;
   logic [31:0]       rsp_rdata_q;
   logic              rsp_err_q;

   logic              accept;
   logic              req_bad;
   logic [31:0]       ram_rdata;
   logic              ram_en;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [31:0]       ram_wdata;
   logic [31:0]       load_data;
   logic [31:0]       merge_data;
   logic [7:0]        lane_byte;
   logic [15:0]       lane_half;

   assign req_ready = (state_q == IDLE);
   assign accept    = req_valid && req_ready;

   // Request validation: illegal funct3, misalignment, out-of-range address.
   always_comb begin
      req_bad = 1'b0;
      case (req_funct3)
         F3_B, F3_BU: req_bad = 1'b0;
         F3_H, F3_HU: req_bad = req_addr[0];
         F3_W:        req_bad = (req_addr[1:0] != 2'b00);
         default:     req_bad = 1'b1;
      endcase
      if (req_we && req_funct3[2]) req_bad = 1'b1;
      if (|req_addr[31:ADDR_W+2])  req_bad = 1'b1;
   end

   // RAM port: IDLE issues sw writes and read-for-load/RMW reads; RD issues
   // the merged sub-word write. Gating with reset keeps the RAM untouched
   // while reset is held, and a reset during RD forces IDLE so the pending
   // RMW write never happens.
   always_comb begin
      ram_en    = 1'b0;
      ram_we    = 1'b0;
      ram_addr  = req_addr[ADDR_W+1:2];
      ram_wdata = req_wdata;
      if (state_q == RD) begin
         ram_en    = reset && we_q;
         ram_we    = 1'b1;
         ram_addr  = idx_q;
         ram_wdata = merge_data;
      end else if (state_q == IDLE) begin
         ram_en = reset && accept && !req_bad;
         ram_we = req_we && (req_funct3 == F3_W);
      end
   end

   sp_ram #(.ADDR_W(ADDR_W)) u_ram (
      .clk   (clk),
      .en    (ram_en),
      .we    (ram_we),
      .addr  (ram_addr),
      .wdata (ram_wdata),
      .rdata (ram_rdata)
   );

   // Lane selection, extension and sub-word merge on the RAM read data.
   always_comb begin
      lane_byte  = ram_rdata[{lane_q, 3'b000} +: 8];
      lane_half  = lane_q[1] ? ram_rdata[31:16] : ram_rdata[15:0];
      load_data  = ram_rdata;
      case (f3_q)
         F3_B:    load_data = {{24{lane_byte[7]}}, lane_byte};
         F3_BU:   load_data = {24'h0, lane_byte};
         F3_H:    load_data = {{16{lane_half[15]}}, lane_half};
         F3_HU:   load_data = {16'h0, lane_half};
         default: load_data = ram_rdata;
      endcase
      merge_data = ram_rdata;
      if (f3_q == F3_B) begin
         merge_data[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
      end else begin
         merge_data[{lane_q[1], 4'b0000} +: 16] = wdata_q;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         we_q        <= 1'b0;
         f3_q        <= 3'b000;
         lane_q      <= 2'b00;
         idx_q       <= '0;
         wdata_q     <= 16'h0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= 32'h0;
         rsp_err_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  we_q    <= req_we;
                  f3_q    <= req_funct3;
                  lane_q  <= req_addr[1:0];
                  idx_q   <= req_addr[ADDR_W+1:2];
                  wdata_q <= req_wdata[15:0];
                  if (req_bad || (req_we && req_funct3 == F3_W)) begin
                     state_q     <= RESP;
                     rsp_valid_q <= 1'b1;
                     rsp_err_q   <= req_bad;
                     rsp_rdata_q <= 32'h0;
                  end else begin
                     state_q <= RD;
                  end
               end
            end
            RD: begin
               state_q     <= RESP;
               rsp_valid_q <= 1'b1;
               rsp_err_q   <= 1'b0;
               rsp_rdata_q <= we_q ? 32'h0 : load_data;
            end
            default: begin
               state_q     <= IDLE;
               rsp_valid_q <= 1'b0;
               rsp_rdata_q <= 32'h0;
               rsp_err_q   <= 1'b0;
            end
         endcase
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;
   assign dbg_state = state_q;

endmodule
